// File: rtl/merge_tree_feeder_pkg.sv
// Shared types and helpers for the merge tree leaf feeder.
package merge_tree_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SENT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned MAX_DATW = 1024;

    // Max-key sentinel: low keyw bits set, payload bits above the key clear.
    function automatic logic [MAX_DATW-1:0] sentinel_val(input int unsigned datw,
                                                         input int unsigned keyw);
        logic [MAX_DATW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_DATW; i++) begin
            if (i < keyw && i < datw) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic int unsigned slot_off(input int unsigned datw, input int unsigned c);
        return datw * c;
    endfunction

endpackage

// File: rtl/merge_tree_feeder.sv
// Producer side of the merge sorter tree leaf interface: routes records to leaves,
// appends a per-run sentinel, flags DONE. Optional record counter: MERGE_TREE_FEEDER_CNT_EN.
module merge_tree_feeder
    import merge_tree_feeder_pkg::*;
#(
    parameter int unsigned W_LOG = 2,
    parameter int unsigned DATW  = 64,
    parameter int unsigned KEYW  = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATW-1:0]            IN_DIN,
    input  logic [W_LOG-1:0]           IN_IDX,
    input  logic                       IN_LAST,
    input  logic                       IN_VLD,
    output logic                       IN_RDY,
    output logic [(DATW<<W_LOG)-1:0]   DIN,
    output logic [(1<<W_LOG)-1:0]      DINEN,
    input  logic [(1<<W_LOG)-1:0]      FULL,
    output logic                       DONE,
    output logic                       ERR
`ifdef MERGE_TREE_FEEDER_CNT_EN
    ,
    output logic [31:0]                REC_CNT
`endif
);

    localparam int unsigned NCH = 1 << W_LOG;
    localparam logic [DATW-1:0] SENTINEL = DATW'(sentinel_val(DATW, KEYW));

    state_e             state;
    logic [DATW-1:0]    dreg;
    logic [NCH-1:0]     term;
    logic [W_LOG-1:0]   sc;
    logic [NCH-1:0]     elig;
    logic [NCH-1:0]     idx_oh;
    logic [NCH-1:0]     sc_oh;
    logic               xfer;
    logic               issue_rec;

    // A channel just written this cycle is skipped, so a full leaf is never written.
    assign elig      = ~FULL & ~DINEN;
    assign idx_oh    = NCH'(1) << IN_IDX;
    assign sc_oh     = NCH'(1) << sc;
    assign xfer      = IN_VLD & IN_RDY;
    assign issue_rec = (state == ST_IDLE) & xfer & ~term[IN_IDX];

    always_comb begin
        IN_RDY = 1'b0;
        case (state)
            ST_IDLE: IN_RDY = elig[IN_IDX] | term[IN_IDX];
            ST_SENT: IN_RDY = 1'b0;
            ST_DONE: IN_RDY = 1'b1;
            default: IN_RDY = 1'b0;
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : g_slot
        assign DIN[slot_off(DATW, c) +: DATW] = dreg;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            dreg  <= '0;
            DINEN <= '0;
            term  <= '0;
            sc    <= '0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            DINEN <= '0;
            case (state)
                ST_IDLE: begin
                    if (issue_rec) begin
                        dreg  <= IN_DIN;
                        DINEN <= idx_oh;
                        if (IN_LAST) begin
                            sc    <= IN_IDX;
                            state <= ST_SENT;
                        end
                    end else if (xfer) begin
                        ERR <= 1'b1;
                    end
                end
                ST_SENT: begin
                    if (elig[sc]) begin
                        dreg  <= SENTINEL;
                        DINEN <= sc_oh;
                        term  <= term | sc_oh;
                        if (&(term | sc_oh)) begin
                            state <= ST_DONE;
                            DONE  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (IN_VLD) ERR <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MERGE_TREE_FEEDER_CNT_EN
    // Counts real records only; sentinels and dropped records are excluded.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) REC_CNT <= '0;
        else if (issue_rec) REC_CNT <= REC_CNT + 32'd1;
    end
`endif

endmodule

// File: tb/tb_merge_tree_feeder.sv
// Self-checking bench for merge_tree_feeder: vector table, corner sequences, random vs model.
module tb_merge_tree_feeder;

    localparam logic [63:0] S = 64'h0000_0000_FFFF_FFFF;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [63:0]  IN_DIN = '0;
    logic [1:0]   IN_IDX = '0;
    logic         IN_LAST = 1'b0;
    logic         IN_VLD = 1'b0;
    logic         IN_RDY;
    logic [255:0] DIN;
    logic [3:0]   DINEN;
    logic [3:0]   FULL = '0;
    logic         DONE;
    logic         ERR;
`ifdef MERGE_TREE_FEEDER_CNT_EN
    logic [31:0]  REC_CNT;
`endif

    int n_chk = 0;
    int n_err = 0;

    merge_tree_feeder #(.W_LOG(2), .DATW(64), .KEYW(32)) dut (
        .CLK(CLK), .RST(RST), .IN_DIN(IN_DIN), .IN_IDX(IN_IDX), .IN_LAST(IN_LAST),
        .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .DIN(DIN), .DINEN(DINEN), .FULL(FULL),
        .DONE(DONE), .ERR(ERR)
`ifdef MERGE_TREE_FEEDER_CNT_EN
        , .REC_CNT(REC_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        vld;
        logic [1:0]  idx;
        logic        last;
        logic [63:0] dat;
        logic [3:0]  full;
        logic        rdy;
        logic [3:0]  dinen;
        logic [63:0] odat;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic v, input logic [1:0] i, input logic l,
                                input logic [63:0] d, input logic [3:0] f, input logic r,
                                input logic [3:0] en, input logic [63:0] od,
                                input logic dn, input logic er);
        vec_t x;
        x.vld = v; x.idx = i; x.last = l; x.dat = d; x.full = f;
        x.rdy = r; x.dinen = en; x.odat = od; x.done = dn; x.err = er;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] i, input logic l,
                         input logic [63:0] d, input logic [3:0] f);
        IN_VLD = v; IN_IDX = i; IN_LAST = l; IN_DIN = d; FULL = f;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(1'b0, 2'd0, 1'b0, 64'd0, 4'd0);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // Reference model state
    bit [3:0]    m_term;
    int          m_pend;
    bit          m_done;
    bit          m_err;
    int          m_last;
    logic [63:0] m_dat;
`ifdef MERGE_TREE_FEEDER_CNT_EN
    logic [31:0] m_cnt;
`endif

    task automatic model_reset();
        m_term = '0; m_pend = -1; m_done = 1'b0; m_err = 1'b0; m_last = -1; m_dat = '0;
`ifdef MERGE_TREE_FEEDER_CNT_EN
        m_cnt = '0;
`endif
    endtask

    task automatic model_check(input string tag);
        logic       er;
        logic [3:0] en;
        if (m_done) er = 1'b1;
        else if (m_pend >= 0) er = 1'b0;
        else er = m_term[IN_IDX] || (!FULL[IN_IDX] && m_last != int'(IN_IDX));
        en = (m_last >= 0) ? 4'(1 << m_last) : 4'd0;
        chk({tag, " rdy"},   256'(IN_RDY), 256'(er));
        chk({tag, " dinen"}, 256'(DINEN),  256'(en));
        chk({tag, " din"},   DIN,          {4{m_dat}});
        chk({tag, " done"},  256'(DONE),   256'(m_done));
        chk({tag, " err"},   256'(ERR),    256'(m_err));
`ifdef MERGE_TREE_FEEDER_CNT_EN
        chk({tag, " cnt"},   256'(REC_CNT), 256'(m_cnt));
`endif
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        int  nxt;
        bit  rdy;
        nxt = -1;
        rdy = m_term[IN_IDX] || (!FULL[IN_IDX] && m_last != int'(IN_IDX));
        if (m_done) begin
            if (IN_VLD) m_err = 1'b1;
        end else if (m_pend >= 0) begin
            if (!FULL[m_pend] && m_last != m_pend) begin
                nxt = m_pend;
                m_dat = S;
                m_term[m_pend] = 1'b1;
                m_pend = -1;
                if (m_term == 4'hF) m_done = 1'b1;
            end
        end else if (IN_VLD && rdy) begin
            if (m_term[IN_IDX]) begin
                m_err = 1'b1;
            end else begin
                nxt = int'(IN_IDX);
                m_dat = IN_DIN;
`ifdef MERGE_TREE_FEEDER_CNT_EN
                m_cnt = m_cnt + 32'd1;
`endif
                if (IN_LAST) m_pend = int'(IN_IDX);
            end
        end
        m_last = nxt;
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 64'd5,  4'h0, 1, 4'h0, 64'd0,  0, 0);
        tbl[1]  = mk(1, 0, 0, 64'd6,  4'h0, 0, 4'h1, 64'd5,  0, 0);
        tbl[2]  = mk(0, 2, 0, 64'd0,  4'h4, 0, 4'h0, 64'd5,  0, 0);
        tbl[3]  = mk(1, 2, 0, 64'd7,  4'h4, 0, 4'h0, 64'd5,  0, 0);
        tbl[4]  = mk(1, 2, 0, 64'd7,  4'h0, 1, 4'h0, 64'd5,  0, 0);
        tbl[5]  = mk(1, 1, 1, 64'd9,  4'h0, 1, 4'h4, 64'd7,  0, 0);
        tbl[6]  = mk(1, 3, 0, 64'd11, 4'h0, 0, 4'h2, 64'd9,  0, 0);
        tbl[7]  = mk(1, 3, 0, 64'd11, 4'h0, 0, 4'h0, 64'd9,  0, 0);
        tbl[8]  = mk(1, 3, 0, 64'd11, 4'h0, 1, 4'h2, S,      0, 0);
        tbl[9]  = mk(1, 0, 1, 64'd13, 4'h0, 1, 4'h8, 64'd11, 0, 0);
        tbl[10] = mk(0, 0, 0, 64'd0,  4'h0, 0, 4'h1, 64'd13, 0, 0);
        tbl[11] = mk(0, 0, 0, 64'd0,  4'h0, 0, 4'h0, 64'd13, 0, 0);
        tbl[12] = mk(1, 2, 1, 64'd14, 4'h0, 1, 4'h1, S,      0, 0);
        tbl[13] = mk(0, 0, 0, 64'd0,  4'h0, 0, 4'h4, 64'd14, 0, 0);
        tbl[14] = mk(0, 0, 0, 64'd0,  4'h4, 0, 4'h0, 64'd14, 0, 0);
        tbl[15] = mk(0, 0, 0, 64'd0,  4'h0, 0, 4'h0, 64'd14, 0, 0);
        tbl[16] = mk(1, 3, 1, 64'd15, 4'h0, 1, 4'h4, S,      0, 0);
        tbl[17] = mk(0, 0, 0, 64'd0,  4'h0, 0, 4'h8, 64'd15, 0, 0);
        tbl[18] = mk(0, 0, 0, 64'd0,  4'h0, 0, 4'h0, 64'd15, 0, 0);
        tbl[19] = mk(1, 0, 0, 64'd16, 4'h0, 1, 4'h8, S,      1, 0);
        tbl[20] = mk(0, 0, 0, 64'd0,  4'h0, 1, 4'h0, S,      1, 1);

        // Directed vector table from reset
        do_reset();
        #1;
        chk("reset dinen", 256'(DINEN), 256'd0);
        chk("reset din",   DIN,         256'd0);
        chk("reset done",  256'(DONE),  256'd0);
        chk("reset err",   256'(ERR),   256'd0);
        for (int i = 0; i < 21; i++) begin
            if (i != 0) @(negedge CLK);
            drive(tbl[i].vld, tbl[i].idx, tbl[i].last, tbl[i].dat, tbl[i].full);
            #1;
            chk($sformatf("row%0d rdy", i),   256'(IN_RDY), 256'(tbl[i].rdy));
            chk($sformatf("row%0d dinen", i), 256'(DINEN),  256'(tbl[i].dinen));
            chk($sformatf("row%0d din", i),   DIN,          {4{tbl[i].odat}});
            chk($sformatf("row%0d done", i),  256'(DONE),   256'(tbl[i].done));
            chk($sformatf("row%0d err", i),   256'(ERR),    256'(tbl[i].err));
        end
`ifdef MERGE_TREE_FEEDER_CNT_EN
        chk("table cnt", 256'(REC_CNT), 256'd7);
`endif

        // Reset while a sentinel is pending
        do_reset();
        drive(1'b1, 2'd1, 1'b1, 64'hDEAD, 4'h0);
        @(negedge CLK);
        drive(1'b0, 2'd1, 1'b0, 64'd0, 4'h0);
        #1;
        chk("sent pre dinen", 256'(DINEN), 256'h2);
        chk("sent pre rdy",   256'(IN_RDY), 256'd0);
        RST = 1'b0;
        #1;
        chk("rst dinen", 256'(DINEN), 256'd0);
        chk("rst din",   DIN,         256'd0);
        chk("rst done",  256'(DONE),  256'd0);
        chk("rst err",   256'(ERR),   256'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("post rst%0d dinen", i), 256'(DINEN),  256'd0);
            chk($sformatf("post rst%0d rdy", i),   256'(IN_RDY), 256'd1);
        end

        // Three records then the sentinel on the last one's channel
        do_reset();
        drive(1'b1, 2'd0, 1'b0, 64'h10, 4'h0);
        #1 chk("seq6 rdy0", 256'(IN_RDY), 256'd1);
        @(negedge CLK);
        drive(1'b1, 2'd1, 1'b0, 64'h11, 4'h0);
        #1 chk("seq6 rdy1", 256'(IN_RDY), 256'd1);
        @(negedge CLK);
        drive(1'b1, 2'd2, 1'b1, 64'h12, 4'h0);
        #1 chk("seq6 rdy2", 256'(IN_RDY), 256'd1);
        @(negedge CLK);
        drive(1'b0, 2'd0, 1'b0, 64'd0, 4'h0);
        #1;
        chk("seq6 rec dinen", 256'(DINEN), 256'h4);
        chk("seq6 rec din",   DIN,         {4{64'h12}});
        @(negedge CLK);
        #1;
        chk("seq6 gap dinen", 256'(DINEN), 256'h0);
        @(negedge CLK);
        #1;
        chk("seq6 sent dinen", 256'(DINEN), 256'h4);
        chk("seq6 sent din",   DIN,         {4{S}});
`ifdef MERGE_TREE_FEEDER_CNT_EN
        chk("seq6 cnt", 256'(REC_CNT), 256'd3);
`endif

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [3:0] f;
            @(negedge CLK);
            if (cyc % 300 == 299) begin
                RST = 1'b0;
                model_reset();
                #1;
                model_check($sformatf("rnd%0d rst", cyc));
                @(negedge CLK);
                RST = 1'b1;
            end
            for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0), {$urandom, $urandom}, f);
            #1;
            model_check($sformatf("rnd%0d", cyc));
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
